// File: rtl/stream_pkt_meter.sv
// Forwards a keep-masked stream through a 2-entry skid buffer and emits one word-count descriptor per packet.
// Define STREAM_METER_KEEP_CHECK_EN to flag non-contiguous keep masks in the descriptor error bit.
module stream_pkt_meter #(
  parameter int unsigned T_DATA_WIDTH = 4,
  parameter int unsigned KEEP_WIDTH   = 7,
  parameter int unsigned LEN_WIDTH    = 8,
  parameter int unsigned DESC_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [T_DATA_WIDTH-1:0] s_data_i [KEEP_WIDTH],
  input  logic [KEEP_WIDTH-1:0]   s_keep_i,
  input  logic                    s_last_i,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  output logic [T_DATA_WIDTH-1:0] m_data_o [KEEP_WIDTH],
  output logic [KEEP_WIDTH-1:0]   m_keep_o,
  output logic                    m_last_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i,
  output logic [LEN_WIDTH-1:0]    len_data_o,
  output logic                    len_err_o,
  output logic                    len_valid_o,
  input  logic                    len_ready_i
);
  localparam int unsigned CNT_W = $clog2(KEEP_WIDTH + 1);
  localparam int unsigned AW    = $clog2(DESC_DEPTH);
  localparam int unsigned PTR_W = AW + 1;
  localparam logic [LEN_WIDTH:0] LEN_MAX = {1'b0, {LEN_WIDTH{1'b1}}};

  typedef struct packed {
    logic [KEEP_WIDTH-1:0][T_DATA_WIDTH-1:0] data;
    logic [KEEP_WIDTH-1:0]                   keep;
    logic                                    last;
  } beat_t;

  typedef struct packed {
    logic                 err;
    logic [LEN_WIDTH-1:0] len;
  } desc_t;

  typedef enum logic [1:0] {ST_IDLE, ST_PKT, ST_HOLD} state_e;

  beat_t            in_beat;
  beat_t            out_q, out_d, skid_q, skid_d;
  logic             out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
  logic             s_ready_q, s_ready_d;
  logic             acc_beat, pop_beat;

  state_e           state_q, state_d;
  logic [LEN_WIDTH-1:0] acc_q, acc_d;
  logic             sat_q, sat_d, kerr_q, kerr_d;
  desc_t            hold_q, hold_d;
  logic [CNT_W-1:0] beat_cnt;
  logic [LEN_WIDTH:0] sum;
  logic             beat_sat, beat_kerr;
  desc_t            new_desc, push_desc;

  logic             push_req, push_ok, push, pop, fifo_full;
  desc_t            mem_q [DESC_DEPTH];
  desc_t            mem_d [DESC_DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  desc_t            head_q, head_d;
  logic             lvld_q, lvld_d;

  assign acc_beat  = s_valid_i & s_ready_q;
  assign pop_beat  = out_vld_q & m_ready_i;
  assign pop       = lvld_q & len_ready_i;
  assign fifo_full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign push_ok   = !fifo_full || pop;
  assign push      = push_req & push_ok;

  always_comb begin
    in_beat = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) in_beat.data[i] = s_data_i[i];
    in_beat.keep = s_keep_i;
    in_beat.last = s_last_i;
  end

  // Skid buffer: out_q is the head, skid_q absorbs the beat accepted while the head is stalled.
  always_comb begin
    out_d      = out_q;
    out_vld_d  = out_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (pop_beat || !out_vld_q) begin
      if (skid_vld_q) begin
        out_d      = skid_q;
        out_vld_d  = 1'b1;
        skid_vld_d = acc_beat;
        if (acc_beat) skid_d = in_beat;
      end else begin
        out_vld_d = acc_beat;
        if (acc_beat) out_d = in_beat;
      end
    end else if (acc_beat) begin
      skid_d     = in_beat;
      skid_vld_d = 1'b1;
    end
  end

  // Ready is registered, so it must guarantee room for one more beat whatever the sink does next.
  assign s_ready_d = !(out_vld_d && skid_vld_d) && (state_d != ST_HOLD);

  always_comb begin
    beat_cnt = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) beat_cnt = beat_cnt + CNT_W'(s_keep_i[i]);
    sum      = {1'b0, acc_q} + (LEN_WIDTH+1)'(beat_cnt);
    beat_sat = sum > LEN_MAX;
`ifdef STREAM_METER_KEEP_CHECK_EN
    beat_kerr = ((s_keep_i & (s_keep_i + KEEP_WIDTH'(1))) != '0) || ((s_keep_i == '0) && !s_last_i);
`else
    beat_kerr = 1'b0;
`endif
    new_desc.len = beat_sat ? LEN_WIDTH'(LEN_MAX) : LEN_WIDTH'(sum);
    new_desc.err = sat_q | beat_sat | kerr_q | beat_kerr;
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    sat_d     = sat_q;
    kerr_d    = kerr_q;
    hold_d    = hold_q;
    push_req  = 1'b0;
    push_desc = new_desc;
    unique case (state_q)
      ST_IDLE, ST_PKT: begin
        if (acc_beat) begin
          if (s_last_i) begin
            push_req = 1'b1;
            acc_d    = '0;
            sat_d    = 1'b0;
            kerr_d   = 1'b0;
            if (push_ok) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_HOLD;
              hold_d  = new_desc;
            end
          end else begin
            state_d = ST_PKT;
            acc_d   = new_desc.len;
            sat_d   = sat_q | beat_sat;
            kerr_d  = kerr_q | beat_kerr;
          end
        end
      end
      ST_HOLD: begin
        push_req  = 1'b1;
        push_desc = hold_q;
        if (push_ok) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Descriptor FIFO with a registered copy of the head entry driving the len_* outputs.
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_q[AW-1:0]] = push_desc;
    wr_d   = wr_q + PTR_W'(push);
    rd_d   = rd_q + PTR_W'(pop);
    lvld_d = (wr_d != rd_d);
    head_d = lvld_d ? mem_d[rd_d[AW-1:0]] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q      <= '0;
      out_vld_q  <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
      s_ready_q  <= 1'b0;
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      sat_q      <= 1'b0;
      kerr_q     <= 1'b0;
      hold_q     <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      head_q     <= '0;
      lvld_q     <= 1'b0;
      for (int i = 0; i < DESC_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      out_q      <= out_d;
      out_vld_q  <= out_vld_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
      s_ready_q  <= s_ready_d;
      state_q    <= state_d;
      acc_q      <= acc_d;
      sat_q      <= sat_d;
      kerr_q     <= kerr_d;
      hold_q     <= hold_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      head_q     <= head_d;
      lvld_q     <= lvld_d;
      mem_q      <= mem_d;
    end
  end

  always_comb begin
    for (int i = 0; i < KEEP_WIDTH; i++) m_data_o[i] = out_q.data[i];
  end

  assign s_ready_o   = s_ready_q;
  assign m_valid_o   = out_vld_q;
  assign m_keep_o    = out_q.keep;
  assign m_last_o    = out_q.last;
  assign len_valid_o = lvld_q;
  assign len_data_o  = head_q.len;
  assign len_err_o   = head_q.err;

endmodule

// File: tb/tb_stream_pkt_meter.sv
// Randomized bench for stream_pkt_meter against a queue-based packet/descriptor model.
module tb_stream_pkt_meter;
  localparam int unsigned TDW = 4;
  localparam int unsigned KW  = 7;
  localparam int unsigned LW  = 8;
  localparam int unsigned DD  = 4;
  localparam int LEN_MAX = (1 << LW) - 1;
`ifdef STREAM_METER_KEEP_CHECK_EN
  localparam logic KCHK = 1'b1;
`else
  localparam logic KCHK = 1'b0;
`endif

  typedef struct packed {
    logic [KW*TDW-1:0] data;
    logic [KW-1:0]     keep;
    logic              last;
  } tb_beat_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [TDW-1:0] s_data_i [KW];
  logic [KW-1:0]  s_keep_i;
  logic           s_last_i, s_valid_i, s_ready_o;
  logic [TDW-1:0] m_data_o [KW];
  logic [KW-1:0]  m_keep_o;
  logic           m_last_o, m_valid_o, m_ready_i;
  logic [LW-1:0]  len_data_o;
  logic           len_err_o, len_valid_o, len_ready_i;

  always #5 clk = ~clk;

  stream_pkt_meter #(.T_DATA_WIDTH(TDW), .KEEP_WIDTH(KW), .LEN_WIDTH(LW), .DESC_DEPTH(DD)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_data_i(s_data_i), .s_keep_i(s_keep_i), .s_last_i(s_last_i),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .m_data_o(m_data_o), .m_keep_o(m_keep_o), .m_last_o(m_last_o),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .len_data_o(len_data_o), .len_err_o(len_err_o),
    .len_valid_o(len_valid_o), .len_ready_i(len_ready_i)
  );

  tb_beat_t      exp_q[$];
  logic [LW:0]   desc_q[$];
  int            pk_acc;
  logic          pk_sat, pk_kerr;
  int            vectors, miscompares, cyc;
  logic [KW-1:0] t2_keep [3];
  logic [3:0]    pat;
  logic          took;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int popcnt(input logic [KW-1:0] k);
    int n;
    n = 0;
    for (int i = 0; i < KW; i++) if (k[i]) n++;
    return n;
  endfunction

  function automatic tb_beat_t pack_in();
    tb_beat_t b;
    for (int i = 0; i < KW; i++) b.data[i*TDW +: TDW] = s_data_i[i];
    b.keep = s_keep_i;
    b.last = s_last_i;
    return b;
  endfunction

  function automatic tb_beat_t pack_out();
    tb_beat_t b;
    for (int i = 0; i < KW; i++) b.data[i*TDW +: TDW] = m_data_o[i];
    b.keep = m_keep_o;
    b.last = m_last_o;
    return b;
  endfunction

  function automatic logic [KW-1:0] rand_keep();
    int sel;
    sel = $urandom_range(3);
    case (sel)
      0:       return '1;
      1:       return KW'((1 << $urandom_range(KW)) - 1);
      default: return KW'($urandom);
    endcase
  endfunction

  task automatic model_reset();
    exp_q.delete();
    desc_q.delete();
    pk_acc  = 0;
    pk_sat  = 1'b0;
    pk_kerr = 1'b0;
  endtask

  // Reference: packet length is the saturating sum of keep popcounts; descriptors leave in packet order.
  task automatic model_accept();
    int sum;
    sum = pk_acc + popcnt(s_keep_i);
    if (sum > LEN_MAX) begin
      pk_acc = LEN_MAX;
      pk_sat = 1'b1;
    end else begin
      pk_acc = sum;
    end
`ifdef STREAM_METER_KEEP_CHECK_EN
    if (s_keep_i != KW'((1 << popcnt(s_keep_i)) - 1)) pk_kerr = 1'b1;
    if (s_keep_i == '0 && !s_last_i) pk_kerr = 1'b1;
`endif
    exp_q.push_back(pack_in());
    if (s_last_i) begin
      desc_q.push_back({pk_sat | pk_kerr, LW'(pk_acc)});
      pk_acc  = 0;
      pk_sat  = 1'b0;
      pk_kerr = 1'b0;
    end
  endtask

  // One clock: score the handshakes visible now, advance, then verify stalled outputs held.
  task automatic step();
    tb_beat_t   b, m_snap;
    logic [LW:0] d, l_snap;
    logic       stall_m, stall_l;
    if (s_valid_i && s_ready_o) model_accept();
    if (m_valid_o && m_ready_i) begin
      if (exp_q.size() == 0) check("beat_spurious", 64'(m_valid_o), 64'd0);
      else begin
        b = exp_q.pop_front();
        check("beat", 64'(pack_out()), 64'(b));
      end
    end
    if (len_valid_o && len_ready_i) begin
      if (desc_q.size() == 0) check("desc_spurious", 64'(len_valid_o), 64'd0);
      else begin
        d = desc_q.pop_front();
        check("desc", 64'({len_err_o, len_data_o}), 64'(d));
      end
    end
    stall_m = m_valid_o && !m_ready_i;
    m_snap  = pack_out();
    stall_l = len_valid_o && !len_ready_i;
    l_snap  = {len_err_o, len_data_o};
    @(posedge clk);
    #1;
    cyc++;
    if (stall_m) check("m_hold", 64'({m_valid_o, pack_out()}), 64'({1'b1, m_snap}));
    if (stall_l) check("len_hold", 64'({len_valid_o, len_err_o, len_data_o}), 64'({1'b1, l_snap}));
  endtask

  task automatic set_beat(input logic [KW-1:0] k, input logic l);
    for (int i = 0; i < KW; i++) s_data_i[i] = TDW'($urandom);
    s_keep_i = k;
    s_last_i = l;
  endtask

  task automatic drive_beat(input logic [KW-1:0] k, input logic l);
    logic acc;
    set_beat(k, l);
    s_valid_i = 1'b1;
    for (int t = 0; t < 64; t++) begin
      acc = s_ready_o;
      step();
      if (acc) return;
    end
    check("accept_timeout", 64'(s_ready_o), 64'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    s_valid_i   = 1'b0;
    m_ready_i   = 1'b1;
    len_ready_i = 1'b1;
    while ((exp_q.size() != 0 || desc_q.size() != 0 || m_valid_o || len_valid_o) && n < 300) begin
      step();
      n++;
    end
    check("drain_m_valid", 64'(m_valid_o), 64'd0);
    check("drain_len_valid", 64'(len_valid_o), 64'd0);
    check("drain_beats_left", 64'(exp_q.size()), 64'd0);
    check("drain_desc_left", 64'(desc_q.size()), 64'd0);
  endtask

  task automatic expect_desc(input string tag, input int len, input logic err);
    check(tag, 64'({len_valid_o, len_err_o, len_data_o}), 64'({1'b1, err, LW'(len)}));
  endtask

  initial begin
    vectors = 0; miscompares = 0; cyc = 0;
    rst_n = 1'b0; s_valid_i = 1'b0; s_keep_i = '0; s_last_i = 1'b0;
    m_ready_i = 1'b1; len_ready_i = 1'b1;
    for (int i = 0; i < KW; i++) s_data_i[i] = '0;
    t2_keep[0] = 7'h7F; t2_keep[1] = 7'h7F; t2_keep[2] = 7'h07;
    pat = 4'b1001;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check("rst_s_ready", 64'(s_ready_o), 64'd0);
    check("rst_m", 64'({m_valid_o, m_last_o, m_keep_o}), 64'd0);
    check("rst_len", 64'({len_valid_o, len_err_o, len_data_o}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_release_ready", 64'(s_ready_o), 64'd1);

    // single full beat
    drive_beat(7'h7F, 1'b1);
    s_valid_i = 1'b0;
    check("t1_m_valid", 64'(m_valid_o), 64'd1);
    check("t1_m_ctl", 64'({m_last_o, m_keep_o}), 64'({1'b1, 7'h7F}));
    expect_desc("t1_desc", 7, 1'b0);

    // three back-to-back beats
    begin
      int c0;
      c0 = cyc;
      for (int b = 0; b < 3; b++) begin
        check("t2_ready", 64'(s_ready_o), 64'd1);
        drive_beat(t2_keep[b], b == 2);
      end
      s_valid_i = 1'b0;
      check("t2_cycles", 64'(cyc - c0), 64'd3);
      expect_desc("t2_desc", 17, 1'b0);
    end
    drain();

    // saturation then zero-keep last
    for (int b = 0; b < 40; b++) drive_beat(7'h7F, 1'b0);
    drive_beat(7'h00, 1'b1);
    s_valid_i = 1'b0;
    expect_desc("sat_desc", LEN_MAX, 1'b1);
    drain();
    drive_beat(7'h00, 1'b1);
    s_valid_i = 1'b0;
    expect_desc("zero_len", 0, 1'b0);
    drain();
    drive_beat(7'h00, 1'b0);
    drive_beat(7'h07, 1'b1);
    s_valid_i = 1'b0;
    expect_desc("mid_zero", 3, KCHK);
    drain();
    drive_beat(7'h05, 1'b1);
    s_valid_i = 1'b0;
    expect_desc("keep_05", 2, KCHK);
    drain();

    // descriptor FIFO overflow stalls the input until one pop
    len_ready_i = 1'b0;
    for (int k = 0; k < 5; k++) drive_beat(KW'((1 << (k + 2)) - 1), 1'b1);
    s_valid_i = 1'b0;
    check("t4_ready_low", 64'(s_ready_o), 64'd0);
    repeat (3) step();
    check("t4_still_low", 64'(s_ready_o), 64'd0);
    check("t4_len_valid", 64'(len_valid_o), 64'd1);
    len_ready_i = 1'b1;
    step();
    len_ready_i = 1'b0;
    check("t4_release", 64'(s_ready_o), 64'd1);
    drain();

    // sink ready pattern 1,0,0,1 under continuous input
    set_beat(rand_keep(), ($urandom_range(99) < 30));
    s_valid_i = 1'b1;
    for (int c = 0; c < 24; c++) begin
      m_ready_i = pat[c % 4];
      took = s_ready_o;
      step();
      if (took) set_beat(rand_keep(), ($urandom_range(99) < 30));
    end
    drain();

    // random traffic with one mid-stream reset
    s_valid_i = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      m_ready_i   = ($urandom_range(99) < 75);
      len_ready_i = ($urandom_range(99) < 60);
      if (!s_valid_i && ($urandom_range(99) < 70)) begin
        set_beat(rand_keep(), ($urandom_range(99) < 25));
        s_valid_i = 1'b1;
      end
      took = s_valid_i && s_ready_o;
      step();
      if (took) s_valid_i = 1'b0;
      if (c == 1000) begin
        s_valid_i = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mrst_s_ready", 64'(s_ready_o), 64'd0);
        check("mrst_outs", 64'({m_valid_o, len_valid_o, len_err_o, len_data_o}), 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("mrst_ready_back", 64'(s_ready_o), 64'd1);
      end
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
